// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 key tracker: drains the keyboard FIFO, decodes make/break/extended
// sequences into held W/A/S/D/R state, and emits press and rate-limited step pulses.
module ps2_key_tracker #(
  parameter logic [7:0]  W_CODE      = 8'h1D,
  parameter logic [7:0]  A_CODE      = 8'h1C,
  parameter logic [7:0]  S_CODE      = 8'h1B,
  parameter logic [7:0]  D_CODE      = 8'h23,
  parameter logic [7:0]  R_CODE      = 8'h2D,
  parameter int unsigned STEP_PERIOD = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_data,
  input  logic       ps2_ready,
  input  logic       ps2_overflow,
  output logic       ps2_rdn,
  output logic [4:0] key_held,
  output logic [4:0] key_press,
  output logic [3:0] move_step,
  output logic       blue_moving
);

  typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

  localparam logic [31:0] LAST = 32'(STEP_PERIOD - 1);

  state_t      state_q;
  logic [7:0]  byte_q;
  logic        break_q, break_d;
  logic        ext_q, ext_d;
  logic        rdn_q;
  logic [4:0]  held_q, held_d;
  logic [4:0]  press_q, press_d;
  logic [3:0]  step_q, step_d;
  logic        blue_q;
  logic [31:0] cnt_q, cnt_d;
  logic [4:0]  hit;
  logic [3:0]  net_now;

  // {D,S,A,W}: opposing held pairs cancel.
  function automatic logic [3:0] net_dir(input logic [4:0] h);
    return {h[3] & ~h[1], h[2] & ~h[0], h[1] & ~h[3], h[0] & ~h[2]};
  endfunction

  always_comb begin
    hit = '0;
    if (ext_q) begin
      // Only the arrow aliases exist in the extended space.
      case (byte_q)
        8'h75:   hit[0] = 1'b1;
        8'h6B:   hit[1] = 1'b1;
        8'h72:   hit[2] = 1'b1;
        8'h74:   hit[3] = 1'b1;
        default: hit = '0;
      endcase
    end else begin
      hit[0] = (byte_q == W_CODE);
      hit[1] = (byte_q == A_CODE);
      hit[2] = (byte_q == S_CODE);
      hit[3] = (byte_q == D_CODE);
      hit[4] = (byte_q == R_CODE);
    end
  end

  always_comb begin
    held_d  = held_q;
    press_d = '0;
    break_d = break_q;
    ext_d   = ext_q;
    if (state_q == GAP) begin
      if (byte_q == 8'hF0) begin
        break_d = 1'b1;
      end else if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else begin
        if (break_q) begin
          held_d = held_q & ~hit;
        end else begin
          held_d  = held_q | hit;
          press_d = hit & ~held_q;
        end
        break_d = 1'b0;
        ext_d   = 1'b0;
      end
    end
    if (ps2_overflow) begin
      held_d  = '0;
      press_d = '0;
      break_d = 1'b0;
      ext_d   = 1'b0;
    end
  end

  assign net_now = net_dir(held_q);

  // A fresh direction press restarts the cadence and takes priority over a wrap.
  always_comb begin
    step_d = '0;
    cnt_d  = '0;
    if (|press_q[3:0]) begin
      step_d = net_now;
    end else if (|net_now) begin
      if (cnt_q == LAST) begin
        step_d = net_now;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      byte_q  <= '0;
      rdn_q   <= 1'b1;
      break_q <= 1'b0;
      ext_q   <= 1'b0;
      held_q  <= '0;
      press_q <= '0;
      step_q  <= '0;
      blue_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ps2_ready) begin
            byte_q  <= ps2_data;
            rdn_q   <= 1'b0;
            state_q <= POP;
          end
        end
        POP: begin
          rdn_q   <= 1'b1;
          state_q <= GAP;
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          rdn_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
      break_q <= break_d;
      ext_q   <= ext_d;
      held_q  <= held_d;
      press_q <= press_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      blue_q  <= |net_dir(held_d);
    end
  end

  assign ps2_rdn     = rdn_q;
  assign key_held    = held_q;
  assign key_press   = press_q;
  assign move_step   = step_q;
  assign blue_moving = blue_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: a FIFO model feeds bytes, a scoreboard holds expected
// key state per byte, and a cycle model predicts the handshake and step pulses.
module tb_ps2_key_tracker;

  localparam int unsigned PER0 = 10;
  localparam int unsigned PER1 = 4;

  typedef struct {
    logic [7:0]  data;
    logic [4:0]  held;
    logic [4:0]  press;
    int unsigned gap;
    logic        ovf;
    logic        rst_after;
  } vec_t;

  typedef struct {
    logic [4:0] held;
    logic [4:0] press;
  } exp_t;

  logic       clk, rst, ps2_ready, ps2_overflow;
  logic [7:0] ps2_data;
  logic       rdn_o[2];
  logic [4:0] held_o[2], press_o[2];
  logic [3:0] step_o[2];
  logic       blue_o[2];

  ps2_key_tracker #(.STEP_PERIOD(PER0)) u_p10 (
    .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
    .ps2_overflow(ps2_overflow), .ps2_rdn(rdn_o[0]), .key_held(held_o[0]),
    .key_press(press_o[0]), .move_step(step_o[0]), .blue_moving(blue_o[0])
  );

  ps2_key_tracker #(.STEP_PERIOD(PER1)) u_p4 (
    .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
    .ps2_overflow(ps2_overflow), .ps2_rdn(rdn_o[1]), .key_held(held_o[1]),
    .key_press(press_o[1]), .move_step(step_o[1]), .blue_moving(blue_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          vectors;
  int          miscompares;
  vec_t        tbl[$];
  exp_t        exp_q[$];
  logic [7:0]  fifo[$];
  int unsigned per[2];

  logic [4:0]  e_held, e_press;
  logic        e_rdn, rdn_h1, rdn_h2, e_blue;
  int unsigned since_pop;
  int unsigned cnt[2], ncnt[2];
  logic [3:0]  e_step[2], nstep[2];
  logic        rst_p, ovf_p, rdy_p;

  // {D,S,A,W} from signed horizontal/vertical sums.
  function automatic logic [3:0] dir_of(input logic [4:0] h);
    int hz, vt;
    hz = int'(h[3]) - int'(h[1]);
    vt = int'(h[2]) - int'(h[0]);
    return {hz > 0, vt > 0, hz < 0, vt < 0};
  endfunction

  task automatic chk(input string nm, input int k, input logic [4:0] act, input logic [4:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s (P=%0d) t=%0t actual=%b required=%b", nm, per[k], $time, act, req);
    end
  endtask

  task automatic addv(input logic [7:0] d, input logic [4:0] h, input logic [4:0] p,
                      input int unsigned g, input logic o, input logic r);
    vec_t v;
    v.data = d; v.held = h; v.press = p; v.gap = g; v.ovf = o; v.rst_after = r;
    tbl.push_back(v);
  endtask

  task automatic push(input logic [7:0] d, input logic [4:0] h, input logic [4:0] p);
    exp_t e;
    e.held = h; e.press = p;
    fifo.push_back(d);
    exp_q.push_back(e);
    ps2_ready = 1'b1;
    ps2_data  = fifo[0];
  endtask

  task automatic cycle();
    exp_t e;
    logic [3:0] dir;
    rst_p = rst;
    ovf_p = ps2_overflow;
    rdy_p = ps2_ready;
    @(negedge clk);
    #1;
    if (rst_p) begin
      e_held = '0; e_press = '0; e_rdn = 1'b1;
      rdn_h1 = 1'b1; rdn_h2 = 1'b1; since_pop = 9;
      for (int k = 0; k < 2; k++) begin
        cnt[k] = 0; e_step[k] = '0;
      end
    end else begin
      e_rdn = !(rdy_p && since_pop >= 2);
      for (int k = 0; k < 2; k++) begin
        e_step[k] = nstep[k]; cnt[k] = ncnt[k];
      end
      e_press = '0;
      if (!rdn_h2) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL scoreboard t=%0t actual=byte decoded required=no pending byte", $time);
        end else begin
          e = exp_q.pop_front();
          e_held = e.held; e_press = e.press;
        end
      end
      if (ovf_p) begin
        e_held = '0; e_press = '0;
      end
      rdn_h2 = rdn_h1;
      rdn_h1 = e_rdn;
      since_pop = e_rdn ? ((since_pop < 9) ? since_pop + 1 : 9) : 0;
    end
    dir = dir_of(e_held);
    e_blue = |dir;
    for (int k = 0; k < 2; k++) begin
      chk("ps2_rdn", k, 5'(rdn_o[k]), 5'(e_rdn));
      chk("key_held", k, held_o[k], e_held);
      chk("key_press", k, press_o[k], e_press);
      chk("move_step", k, 5'(step_o[k]), 5'(e_step[k]));
      chk("blue_moving", k, 5'(blue_o[k]), 5'(e_blue));
      if (|e_press[3:0]) begin
        nstep[k] = dir; ncnt[k] = 0;
      end else if (dir != 4'b0000) begin
        if (cnt[k] == per[k] - 1) begin
          nstep[k] = dir; ncnt[k] = 0;
        end else begin
          nstep[k] = '0; ncnt[k] = cnt[k] + 1;
        end
      end else begin
        nstep[k] = '0; ncnt[k] = 0;
      end
    end
    if (rdn_o[0] === 1'b0 && fifo.size() > 0) void'(fifo.pop_front());
    ps2_ready = (fifo.size() > 0);
    ps2_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 300; i++) begin
      if (fifo.size() == 0 && exp_q.size() == 0 && since_pop >= 2) begin
        done = 1;
        break;
      end
      cycle();
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL drain t=%0t actual=%0d bytes pending required=0", $time, exp_q.size());
    end
  endtask

  initial begin
    bit found;
    vectors = 0; miscompares = 0;
    per[0] = PER0; per[1] = PER1;
    rst = 1'b1; ps2_ready = 1'b0; ps2_overflow = 1'b0; ps2_data = 8'h00;
    rdn_h1 = 1'b1; rdn_h2 = 1'b1; since_pop = 9;
    for (int k = 0; k < 2; k++) begin
      nstep[k] = '0; ncnt[k] = 0;
    end

    //   data   held    press   gap ovf rst
    addv(8'h1C, 5'h02, 5'h02, 5, 0, 0);
    addv(8'hF0, 5'h02, 5'h00, 0, 0, 0);
    addv(8'h1C, 5'h00, 5'h00, 5, 0, 0);
    addv(8'h23, 5'h08, 5'h08, 25, 0, 0);
    addv(8'h23, 5'h08, 5'h00, 0, 0, 0);
    addv(8'h23, 5'h08, 5'h00, 12, 0, 0);
    addv(8'hF0, 5'h08, 5'h00, 0, 0, 0);
    addv(8'h23, 5'h00, 5'h00, 12, 0, 0);
    addv(8'hE0, 5'h00, 5'h00, 0, 0, 0);
    addv(8'h75, 5'h01, 5'h01, 0, 0, 0);
    addv(8'h1B, 5'h05, 5'h04, 25, 0, 0);
    addv(8'hE0, 5'h05, 5'h00, 0, 0, 0);
    addv(8'hF0, 5'h05, 5'h00, 0, 0, 0);
    addv(8'h75, 5'h04, 5'h00, 25, 0, 0);
    addv(8'hF0, 5'h04, 5'h00, 0, 0, 0);
    addv(8'h1B, 5'h00, 5'h00, 3, 0, 0);
    addv(8'hE0, 5'h00, 5'h00, 0, 0, 0);
    addv(8'h1C, 5'h00, 5'h00, 3, 0, 0);
    addv(8'hF0, 5'h00, 5'h00, 0, 0, 0);
    addv(8'h55, 5'h00, 5'h00, 0, 0, 0);
    addv(8'h1C, 5'h02, 5'h02, 0, 0, 0);
    addv(8'hF0, 5'h02, 5'h00, 0, 0, 0);
    addv(8'hE0, 5'h02, 5'h00, 0, 0, 0);
    addv(8'h6B, 5'h00, 5'h00, 3, 0, 0);
    addv(8'hE0, 5'h00, 5'h00, 0, 0, 0);
    addv(8'h6B, 5'h02, 5'h02, 0, 0, 0);
    addv(8'hE0, 5'h02, 5'h00, 0, 0, 0);
    addv(8'hF0, 5'h02, 5'h00, 0, 0, 0);
    addv(8'h6B, 5'h00, 5'h00, 3, 0, 0);
    addv(8'h1C, 5'h02, 5'h02, 0, 0, 0);
    addv(8'h23, 5'h0A, 5'h08, 0, 0, 0);
    addv(8'hF0, 5'h0A, 5'h00, 2, 1, 0);
    addv(8'h23, 5'h08, 5'h08, 0, 0, 0);
    addv(8'hF0, 5'h08, 5'h00, 0, 0, 0);
    addv(8'h23, 5'h00, 5'h00, 3, 0, 0);
    addv(8'h2D, 5'h10, 5'h10, 4, 0, 0);
    addv(8'hF0, 5'h10, 5'h00, 2, 0, 1);
    addv(8'h1D, 5'h01, 5'h01, 8, 0, 0);
    addv(8'hF0, 5'h01, 5'h00, 0, 0, 0);
    addv(8'h1D, 5'h00, 5'h00, 3, 0, 0);

    repeat (3) cycle();
    rst = 1'b0;
    cycle();

    for (int i = 0; i < tbl.size(); i++) begin
      push(tbl[i].data, tbl[i].held, tbl[i].press);
      if (tbl[i].gap != 0 || tbl[i].ovf || tbl[i].rst_after) begin
        drain();
        repeat (tbl[i].gap) cycle();
        if (tbl[i].ovf) begin
          ps2_overflow = 1'b1; cycle(); ps2_overflow = 1'b0; cycle();
        end
        if (tbl[i].rst_after) begin
          rst = 1'b1; cycle(); rst = 1'b0; cycle();
        end
      end
    end
    drain();

    // Press/wrap collision on the 4-cycle instance: A make lands when its counter is at 3.
    push(8'h1D, 5'h01, 5'h01);
    drain();
    repeat (6) cycle();
    found = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (cnt[1] == 0) begin
        found = 1;
        break;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL collision_align t=%0t actual=counter never 0 required=0", $time);
    end
    push(8'h1C, 5'h03, 5'h02);
    drain();
    repeat (12) cycle();
    push(8'hF0, 5'h03, 5'h00);
    push(8'h1D, 5'h02, 5'h00);
    push(8'hF0, 5'h02, 5'h00);
    push(8'h1C, 5'h00, 5'h00);
    drain();
    repeat (5) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
